// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and byte-lane helper.
package ahb_pkg;

  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
  typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD} hsize_e;
  typedef enum logic {HRESP_OKAY, HRESP_ERROR} hresp_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} slv_state_e;

  // Little-endian lane enables for an aligned transfer of the given size.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM: four byte-write lanes and a registered synchronous read.
module ahb_sram_slave_mem #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (we[l]) ram[waddr] <= wdata[8*l +: 8];
      if (re)    q <= ram[raddr];
    end
    assign rdata[8*l +: 8] = q;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: programmable wait states, two-cycle ERROR, write forwarding.
// Define AHB_SLV_PROT_EN to reject user-mode (HPROT[1]=0) accesses at or above PROT_BASE.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_DEPTH   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] PROT_BASE   = 16'hC000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW         = $clog2(MEM_DEPTH);
  localparam logic [16:0] BYTE_SPACE = 17'(MEM_DEPTH * 4);

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [2:0]  size;
  } dp_req_t;

  slv_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  dp_req_t       dp_q;
  logic          dp_vld_q;
  logic          pend_vld_q;
  logic [AW-1:0] pend_word_q;
  logic [3:0]    pend_be_q;
  logic [31:0]   pend_data_q;
  logic [3:0]    fwd_be_q, fwd_be_d;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic          rd_zero_q;
  logic [31:0]   mem_rdata;
  logic          accept, illegal, wr_done;
  logic [AW-1:0] a_word, dp_word;
  logic [3:0]    wr_be;
  logic          unused_ok;

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign a_word  = HADDR[AW+1:2];
  assign dp_word = dp_q.addr[AW+1:2];
  assign wr_be   = byte_en(dp_q.size, dp_q.addr[1:0]);
  // Final edge of a legal write data phase: HWDATA is valid and moves to the pending register.
  assign wr_done = dp_vld_q && dp_q.write && (state_q == S_IDLE);
  assign unused_ok = ^{HBURST, HPROT, HTRANS, dp_q.addr};

  always_comb begin
    illegal = (HSIZE > 3'd2)
           || (HSIZE == HSIZE_HALF && HADDR[0])
           || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
           || ({1'b0, HADDR} >= BYTE_SPACE);
`ifdef AHB_SLV_PROT_EN
    if (!HPROT[1] && HADDR >= PROT_BASE) illegal = 1'b1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (state_q == S_ERR2) HRESP = HRESP_ERROR;
        state_d = S_IDLE;
        if (accept) begin
          if (illegal) state_d = S_ERR1;
          else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The SRAM read on this edge misses both the committing pending write and the
  // write completing now, so overlay their lanes (newest last).
  always_comb begin
    fwd_be_d   = '0;
    fwd_data_d = '0;
    for (int l = 0; l < 4; l++) begin
      if (pend_vld_q && pend_word_q == a_word && pend_be_q[l]) begin
        fwd_be_d[l]           = 1'b1;
        fwd_data_d[8*l +: 8]  = pend_data_q[8*l +: 8];
      end
      if (wr_done && dp_word == a_word && wr_be[l]) begin
        fwd_be_d[l]           = 1'b1;
        fwd_data_d[8*l +: 8]  = HWDATA[8*l +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      dp_vld_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= wr_done;
      if (accept) begin
        dp_vld_q <= !illegal;
        if (!HWRITE) begin
          rd_zero_q <= illegal;
          if (!illegal) begin
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
          end
        end
      end else if (state_q == S_IDLE) begin
        dp_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) dp_q <= '{addr: HADDR, write: HWRITE, size: HSIZE};
    if (wr_done) begin
      pend_word_q <= dp_word;
      pend_be_q   <= wr_be;
      pend_data_q <= HWDATA;
    end
  end

  ahb_sram_slave_mem #(.DEPTH(MEM_DEPTH)) u_mem (
    .clk   (HCLK),
    .we    (pend_be_q & {4{pend_vld_q && !HRESET}}),
    .waddr (pend_word_q),
    .wdata (pend_data_q),
    .re    (accept && !illegal && !HWRITE && !HRESET),
    .raddr (a_word),
    .rdata (mem_rdata)
  );

  always_comb begin
    HRDATA = '0;
    for (int l = 0; l < 4; l++)
      if (!rd_zero_q)
        HRDATA[8*l +: 8] = fwd_be_q[l] ? fwd_data_q[8*l +: 8] : mem_rdata[8*l +: 8];
  end

endmodule
